usb_txn_controller: RTL and testbench

Host-side transaction sequencer that drives bitstream_encoder. It converts one read or write command into the USB packet sequence, then waits for the device response from the receive decoder. OUT transactions send token, DATA0 and wait for ACK/NAK. IN transactions send token, wait for DATA0 and answer ACK/NAK. NAKs, timeouts and receive errors are retried up to a limit, and the result is reported to the command side.

---
 rtl/usb_pkg.sv | 40 ++++
 rtl/txn_timer.sv | 49 ++++
 rtl/usb_txn_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_usb_txn_controller.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : usb_pkg                                                    |
// | Purpose : Shared field widths, PID codes and transaction-sequencer   |
// |           state encoding for the host-side USB transaction logic.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package usb_pkg;

  localparam int ADDR_W = 7;
  localparam int ENDP_W = 4;
  localparam int DATA_W = 64;
  localparam int PID_W  = 4;

  typedef enum logic [PID_W-1:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_DATA0 = 4'b0011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010
  } pid_t;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_TOKEN      = 4'd1,
    ST_TOKEN_WAIT = 4'd2,
    ST_DATA       = 4'd3,
    ST_DATA_WAIT  = 4'd4,
    ST_RX_HS      = 4'd5,
    ST_RX_DATA    = 4'd6,
    ST_SEND_ACK   = 4'd7,
    ST_ACK_WAIT   = 4'd8,
    ST_SEND_NAK   = 4'd9,
    ST_NAK_WAIT   = 4'd10,
    ST_DONE       = 4'd11
  } txn_state_t;

endpackage : usb_pkg
`default_nettype wire

// File: rtl/txn_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : txn_timer                                                  |
// | Purpose : 8-bit device-response timer. Counts enabled cycles from a  |
// |           cleared start and flags the terminal count. Never wraps.   |
// | Ports   : clk, rst_L (async, active-low)                             |
// |           clr_i     - synchronous clear to zero (wins over en_i)     |
// |           en_i      - count one cycle                                |
// |           expired_o - count has reached TERMINAL                     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module txn_timer #(
  parameter int unsigned TERMINAL = 255
) (
  input  logic clk,
  input  logic rst_L,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] c_TERMINAL = 8'(TERMINAL);

  logic [7:0] count_q, count_d;

  // Holds at the terminal count (and at all-ones) so a long wait can never
  // roll over and look like a fresh timer.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != c_TERMINAL) && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == c_TERMINAL);

endmodule : txn_timer
`default_nettype wire

// File: rtl/usb_txn_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : usb_txn_controller                                         |
// | Purpose : Host transaction sequencer. Turns one read/write command   |
// |           into token / DATA0 / handshake packets for the encoder,    |
// |           waits for the device response and retries on NAK, receive  |
// |           error or timeout up to MAX_RETRY failed attempts.          |
// | Ports   : clk, rst_L (async, active-low)                             |
// |           txn_start/read/wdata      - command in (sampled in IDLE)   |
// |           txn_busy/done/ok/rdata    - command status out             |
// |           enc_pktready/pid/addr/endp/data - packet request (held     |
// |                                         until enc_gotpkt)            |
// |           enc_gotpkt, enc_sending   - encoder handshake in           |
// |           rx_valid/pid/data/error   - receive decoder in             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module usb_txn_controller
  import usb_pkg::*;
#(
  parameter int unsigned        MAX_RETRY      = 8,
  parameter int unsigned        TIMEOUT_CYCLES = 255,
  parameter logic [ADDR_W-1:0]  DEV_ADDR       = 7'd5,
  parameter logic [ENDP_W-1:0]  DATA_ENDP      = 4'd4
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              txn_start,
  input  logic              txn_read,
  input  logic [DATA_W-1:0] txn_wdata,
  output logic              txn_busy,
  output logic              txn_done,
  output logic              txn_ok,
  output logic [DATA_W-1:0] txn_rdata,
  output logic              enc_pktready,
  output logic [PID_W-1:0]  enc_pid,
  output logic [ADDR_W-1:0] enc_addr,
  output logic [ENDP_W-1:0] enc_endp,
  output logic [DATA_W-1:0] enc_data,
  input  logic              enc_gotpkt,
  input  logic              enc_sending,
  input  logic              rx_valid,
  input  logic [PID_W-1:0]  rx_pid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_error
);

  localparam logic [3:0] c_MAX_RETRY = 4'(MAX_RETRY);

  txn_state_t        state_q, state_d;
  logic              read_q, read_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        retry_q, retry_d;
  logic              ok_q, ok_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              seen_q, seen_d;
  logic              pktready_q, pktready_d;
  logic [PID_W-1:0]  pid_q, pid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ENDP_W-1:0] endp_q, endp_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic w_rx, w_pkt_cmplt, w_timer_en, w_timer_clr, w_expired;
  logic w_fail, w_success;

  // Responses that overlap our own transmission are line echo, not device.
  assign w_rx        = rx_valid & ~enc_sending;
  // Packet finished: sending was observed high and has now dropped.
  assign w_pkt_cmplt = seen_q & ~enc_sending;
  // Timer runs only while waiting on the device; any other state clears it,
  // so each entry into a receive state starts from zero.
  assign w_timer_en  = (state_q == ST_RX_HS) || (state_q == ST_RX_DATA);
  assign w_timer_clr = ~w_timer_en;

  txn_timer #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_L     (rst_L),
    .clr_i     (w_timer_clr),
    .en_i      (w_timer_en),
    .expired_o (w_expired)
  );

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    wdata_d    = wdata_q;
    retry_d    = retry_q;
    ok_d       = ok_q;
    rdata_d    = rdata_q;
    seen_d     = seen_q;
    pktready_d = pktready_q;
    pid_d      = pid_q;
    addr_d     = addr_q;
    endp_d     = endp_q;
    data_d     = data_q;
    w_fail     = 1'b0;
    w_success  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (txn_start) begin
          read_d  = txn_read;
          wdata_d = txn_wdata;
          retry_d = '0;
          state_d = ST_TOKEN;
        end
      end
      ST_TOKEN, ST_DATA, ST_SEND_ACK, ST_SEND_NAK: begin
        if (enc_gotpkt) begin
          pktready_d = 1'b0;
          seen_d     = enc_sending;
          case (state_q)
            ST_TOKEN:    state_d = ST_TOKEN_WAIT;
            ST_DATA:     state_d = ST_DATA_WAIT;
            ST_SEND_ACK: state_d = ST_ACK_WAIT;
            default:     state_d = ST_NAK_WAIT;
          endcase
        end
      end
      ST_TOKEN_WAIT, ST_DATA_WAIT, ST_ACK_WAIT, ST_NAK_WAIT: begin
        if (enc_sending) begin
          seen_d = 1'b1;
        end
        if (w_pkt_cmplt) begin
          case (state_q)
            ST_TOKEN_WAIT: state_d = read_q ? ST_RX_DATA : ST_DATA;
            ST_DATA_WAIT:  state_d = ST_RX_HS;
            ST_ACK_WAIT:   w_success = 1'b1;
            default:       w_fail    = 1'b1;
          endcase
        end
      end
      // A response arriving on the expiry cycle takes priority over timeout.
      ST_RX_HS: begin
        if (w_rx) begin
          if (!rx_error && (rx_pid == PID_ACK)) w_success = 1'b1;
          else                                  w_fail    = 1'b1;
        end else if (w_expired) begin
          w_fail = 1'b1;
        end
      end
      ST_RX_DATA: begin
        if (w_rx) begin
          if (rx_error) begin
            state_d = ST_SEND_NAK;
          end else if (rx_pid == PID_DATA0) begin
            // The ACK that follows always completes successfully, so the
            // payload can go straight to the result register.
            rdata_d = rx_data;
            state_d = ST_SEND_ACK;
          end else begin
            w_fail = 1'b1;
          end
        end else if (w_expired) begin
          w_fail = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (w_fail) begin
      retry_d = retry_q + 4'd1;
      if (retry_d == c_MAX_RETRY) begin
        ok_d    = 1'b0;
        state_d = ST_DONE;
      end else begin
        state_d = ST_TOKEN;
      end
    end
    if (w_success) begin
      ok_d    = 1'b1;
      state_d = ST_DONE;
    end

    // Load the packet request on entry to a presenting state; fields then
    // stay put until the encoder takes the packet.
    if (state_d != state_q) begin
      case (state_d)
        ST_TOKEN: begin
          pktready_d = 1'b1;
          pid_d      = read_d ? PID_IN : PID_OUT;
          addr_d     = DEV_ADDR;
          endp_d     = DATA_ENDP;
          data_d     = '0;
        end
        ST_DATA: begin
          pktready_d = 1'b1;
          pid_d      = PID_DATA0;
          data_d     = wdata_q;
        end
        ST_SEND_ACK: begin
          pktready_d = 1'b1;
          pid_d      = PID_ACK;
          data_d     = '0;
        end
        ST_SEND_NAK: begin
          pktready_d = 1'b1;
          pid_d      = PID_NAK;
          data_d     = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= ST_IDLE;
      read_q     <= 1'b0;
      wdata_q    <= '0;
      retry_q    <= '0;
      ok_q       <= 1'b0;
      rdata_q    <= '0;
      seen_q     <= 1'b0;
      pktready_q <= 1'b0;
      pid_q      <= '0;
      addr_q     <= '0;
      endp_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      wdata_q    <= wdata_d;
      retry_q    <= retry_d;
      ok_q       <= ok_d;
      rdata_q    <= rdata_d;
      seen_q     <= seen_d;
      pktready_q <= pktready_d;
      pid_q      <= pid_d;
      addr_q     <= addr_d;
      endp_q     <= endp_d;
      data_q     <= data_d;
    end
  end

  assign txn_busy     = (state_q != ST_IDLE);
  assign txn_done     = (state_q == ST_DONE);
  assign txn_ok       = txn_done & ok_q;
  assign txn_rdata    = rdata_q;
  assign enc_pktready = pktready_q;
  assign enc_pid      = pid_q;
  assign enc_addr     = addr_q;
  assign enc_endp     = endp_q;
  assign enc_data     = data_q;

endmodule : usb_txn_controller
`default_nettype wire

// File: tb/tb_usb_txn_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_usb_txn_controller                                      |
// | Purpose : Directed self-checking bench for usb_txn_controller with   |
// |           a behavioural encoder and scripted device responses.       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_usb_txn_controller;

  localparam logic [3:0] P_OUT   = 4'b0001;
  localparam logic [3:0] P_IN    = 4'b1001;
  localparam logic [3:0] P_DATA0 = 4'b0011;
  localparam logic [3:0] P_ACK   = 4'b0010;
  localparam logic [3:0] P_NAK   = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_L;
  logic        txn_start, txn_read;
  logic [63:0] txn_wdata;
  logic        txn_busy, txn_done, txn_ok;
  logic [63:0] txn_rdata;
  logic        enc_pktready;
  logic [3:0]  enc_pid;
  logic [6:0]  enc_addr;
  logic [3:0]  enc_endp;
  logic [63:0] enc_data;
  logic        enc_gotpkt, enc_sending;
  logic        rx_valid, rx_error;
  logic [3:0]  rx_pid;
  logic [63:0] rx_data;

  typedef struct packed {
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
  } pkt_t;

  pkt_t pkt_q[$];
  int   pkt_done = 0;
  logic enc_hold = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc_cnt  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  usb_txn_controller dut (
    .clk          (clk),
    .rst_L        (rst_L),
    .txn_start    (txn_start),
    .txn_read     (txn_read),
    .txn_wdata    (txn_wdata),
    .txn_busy     (txn_busy),
    .txn_done     (txn_done),
    .txn_ok       (txn_ok),
    .txn_rdata    (txn_rdata),
    .enc_pktready (enc_pktready),
    .enc_pid      (enc_pid),
    .enc_addr     (enc_addr),
    .enc_endp     (enc_endp),
    .enc_data     (enc_data),
    .enc_gotpkt   (enc_gotpkt),
    .enc_sending  (enc_sending),
    .rx_valid     (rx_valid),
    .rx_pid       (rx_pid),
    .rx_data      (rx_data),
    .rx_error     (rx_error)
  );

  // Encoder model: take a request, pulse gotpkt, serialise for 3 cycles.
  initial begin : enc_model
    pkt_t p;
    enc_gotpkt  = 1'b0;
    enc_sending = 1'b0;
    forever begin
      @(negedge clk);
      if (enc_pktready === 1'b1 && !enc_hold) begin
        p.pid  = enc_pid;
        p.addr = enc_addr;
        p.endp = enc_endp;
        p.data = enc_data;
        pkt_q.push_back(p);
        enc_gotpkt = 1'b1;
        @(negedge clk);
        enc_gotpkt = 1'b0;
        checks++;
        if (enc_pktready !== 1'b0) begin
          errors++;
          $display("FAIL pktready_drop: got %b expected 0", enc_pktready);
        end
        enc_sending = 1'b1;
        repeat (3) @(negedge clk);
        enc_sending = 1'b0;
        pkt_done++;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_txn(input logic rd, input logic [63:0] wd);
    @(negedge clk);
    txn_start = 1'b1;
    txn_read  = rd;
    txn_wdata = wd;
    @(negedge clk);
    txn_start = 1'b0;
  endtask

  task automatic wait_pkts(input int n);
    int cyc = 0;
    while (pkt_done < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (pkt_done < n) begin
      errors++;
      $display("FAIL wait_pkts: got %0d packets expected %0d", pkt_done, n);
    end
  endtask

  task automatic rx_send(input logic [3:0] pid, input logic [63:0] d, input logic err);
    repeat (2) @(negedge clk);
    rx_valid = 1'b1;
    rx_pid   = pid;
    rx_data  = d;
    rx_error = err;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ok, output logic busy_at,
                           output logic busy_after);
    int cyc = 0;
    while (txn_done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (txn_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: got done=%b expected 1 within %0d cycles", txn_done, budget);
    end
    ok      = txn_ok;
    busy_at = txn_busy;
    @(negedge clk);
    busy_after = txn_busy;
  endtask

  task automatic test_reset();
    rst_L = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({txn_busy, txn_done, txn_ok, enc_pktready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {txn_busy, txn_done, txn_ok, enc_pktready});
    end
    checks++;
    if ({enc_pid, enc_addr, enc_endp, enc_data} !== 79'd0) begin
      errors++;
      $display("FAIL reset_enc_fields: got %h expected 0", {enc_pid, enc_addr, enc_endp, enc_data});
    end
    checks++;
    if (txn_rdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 0", txn_rdata);
    end
    rst_L = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({txn_busy, enc_pktready} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 00", {txn_busy, enc_pktready});
    end
  endtask

  task automatic test_write_ack();
    logic ok, b_at, b_after;
    pkt_q.delete();
    pkt_done = 0;
    start_txn(1'b0, 64'hDEAD_BEEF_0123_4567);
    checks++;
    if (txn_busy !== 1'b1) begin
      errors++;
      $display("FAIL write_busy: got %b expected 1", txn_busy);
    end
    // Second command while busy must be ignored.
    start_txn(1'b1, 64'h0);
    wait_pkts(2);
    rx_send(P_ACK, 64'h0, 1'b0);
    wait_done(500, ok, b_at, b_after);
    repeat (5) @(negedge clk);
    checks++;
    if ({ok, b_at, b_after} !== 3'b110) begin
      errors++;
      $display("FAIL write_ack_status: got ok/busy/busy_after=%b expected 110", {ok, b_at, b_after});
    end
    checks++;
    if (pkt_q.size() != 2) begin
      errors++;
      $display("FAIL write_ack_pktcount: got %0d expected 2", pkt_q.size());
    end
    checks++;
    if ({pkt_q[0].pid, pkt_q[0].addr, pkt_q[0].endp} !== {P_OUT, 7'd5, 4'd4}) begin
      errors++;
      $display("FAIL write_token: got pid/addr/endp %h/%h/%h expected 1/05/4",
               pkt_q[0].pid, pkt_q[0].addr, pkt_q[0].endp);
    end
    checks++;
    if ({pkt_q[1].pid, pkt_q[1].data} !== {P_DATA0, 64'hDEAD_BEEF_0123_4567}) begin
      errors++;
      $display("FAIL write_data0: got pid %h data %h expected 3 deadbeef01234567",
               pkt_q[1].pid, pkt_q[1].data);
    end
  endtask

  task automatic test_write_nak_retry();
    logic ok, b_at, b_after;
    logic [3:0] exp_pid;
    pkt_q.delete();
    pkt_done = 0;
    start_txn(1'b0, 64'h1122_3344_5566_7788);
    for (int a = 0; a < 3; a++) begin
      wait_pkts(2 * (a + 1));
      rx_send((a < 2) ? P_NAK : P_ACK, 64'h0, 1'b0);
    end
    wait_done(500, ok, b_at, b_after);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL nak_retry_ok: got %b expected 1", ok);
    end
    checks++;
    if (pkt_q.size() != 6) begin
      errors++;
      $display("FAIL nak_retry_pktcount: got %0d expected 6", pkt_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      exp_pid = (i % 2 == 0) ? P_OUT : P_DATA0;
      checks++;
      if (pkt_q[i].pid !== exp_pid ||
          (i % 2 == 1 && pkt_q[i].data !== 64'h1122_3344_5566_7788)) begin
        errors++;
        $display("FAIL nak_retry_pkt%0d: got pid %h data %h expected pid %h", i,
                 pkt_q[i].pid, pkt_q[i].data, exp_pid);
      end
    end
  endtask

  task automatic test_read_ack();
    logic ok, b_at, b_after;
    pkt_q.delete();
    pkt_done = 0;
    start_txn(1'b1, 64'h0);
    wait_pkts(1);
    rx_send(P_DATA0, 64'h0F0F_F0F0_AAAA_5555, 1'b0);
    wait_done(500, ok, b_at, b_after);
    checks++;
    if ({ok, b_at, b_after} !== 3'b110) begin
      errors++;
      $display("FAIL read_status: got ok/busy/busy_after=%b expected 110", {ok, b_at, b_after});
    end
    checks++;
    if (txn_rdata !== 64'h0F0F_F0F0_AAAA_5555) begin
      errors++;
      $display("FAIL read_rdata: got %h expected 0f0ff0f0aaaa5555", txn_rdata);
    end
    checks++;
    if (pkt_q.size() != 2 || pkt_q[0].pid !== P_IN || pkt_q[0].addr !== 7'd5 ||
        pkt_q[0].endp !== 4'd4 || pkt_q[1].pid !== P_ACK) begin
      errors++;
      $display("FAIL read_pkts: got n=%0d pid0 %h addr %h endp %h pid1 %h expected 2 9 05 4 2",
               pkt_q.size(), pkt_q[0].pid, pkt_q[0].addr, pkt_q[0].endp, pkt_q[1].pid);
    end
  endtask

  task automatic test_read_error();
    logic ok, b_at, b_after;
    pkt_q.delete();
    pkt_done = 0;
    start_txn(1'b1, 64'h0);
    wait_pkts(1);
    rx_send(P_DATA0, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1);
    wait_pkts(3);
    rx_send(P_DATA0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    wait_done(500, ok, b_at, b_after);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL rderr_ok: got %b expected 1", ok);
    end
    checks++;
    if (txn_rdata !== 64'h1234_5678_9ABC_DEF0) begin
      errors++;
      $display("FAIL rderr_rdata: got %h expected 123456789abcdef0", txn_rdata);
    end
    checks++;
    if (pkt_q.size() != 4 || {pkt_q[0].pid, pkt_q[1].pid, pkt_q[2].pid, pkt_q[3].pid} !==
        {P_IN, P_NAK, P_IN, P_ACK}) begin
      errors++;
      $display("FAIL rderr_pkts: got n=%0d pids %h%h%h%h expected 4 pids 9a92", pkt_q.size(),
               pkt_q[0].pid, pkt_q[1].pid, pkt_q[2].pid, pkt_q[3].pid);
    end
  endtask

  task automatic test_timeout();
    logic ok, b_at, b_after;
    int   t0, dt;
    pkt_q.delete();
    pkt_done = 0;
    t0 = cyc_cnt;
    start_txn(1'b0, 64'hCAFE_F00D_0000_0001);
    wait_done(5000, ok, b_at, b_after);
    dt = cyc_cnt - t0;
    checks++;
    if ({ok, b_at, b_after} !== 3'b010) begin
      errors++;
      $display("FAIL timeout_status: got ok/busy/busy_after=%b expected 010", {ok, b_at, b_after});
    end
    checks++;
    if (pkt_q.size() != 16) begin
      errors++;
      $display("FAIL timeout_pktcount: got %0d expected 16", pkt_q.size());
    end
    checks++;
    if (dt < 2048 || dt > 2400) begin
      errors++;
      $display("FAIL timeout_duration: got %0d cycles expected 2048..2400", dt);
    end
    checks++;
    if (txn_rdata !== 64'h1234_5678_9ABC_DEF0) begin
      errors++;
      $display("FAIL timeout_rdata_hold: got %h expected 123456789abcdef0", txn_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic ok, b_at, b_after;
    logic saw_done = 1'b0;
    int   cyc = 0;
    enc_hold = 1'b1;
    pkt_q.delete();
    pkt_done = 0;
    start_txn(1'b0, 64'h5555_AAAA_5555_AAAA);
    while (enc_pktready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (enc_pktready !== 1'b1 || enc_pid !== P_OUT) begin
      errors++;
      $display("FAIL midrst_held: got pktready %b pid %h expected 1 1", enc_pktready, enc_pid);
    end
    #2 rst_L = 1'b0;
    #1;
    checks++;
    if ({enc_pktready, txn_busy} !== 2'b00 || txn_rdata !== 64'd0) begin
      errors++;
      $display("FAIL midrst_async: got pktready/busy %b rdata %h expected 00 0",
               {enc_pktready, txn_busy}, txn_rdata);
    end
    repeat (4) begin
      @(negedge clk);
      if (txn_done === 1'b1) saw_done = 1'b1;
    end
    rst_L    = 1'b1;
    enc_hold = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (txn_done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || pkt_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_no_done: got done_seen %b packets %0d expected 0 0", saw_done,
               pkt_q.size());
    end
    start_txn(1'b0, 64'h0BAD_CAFE_1234_0000);
    wait_pkts(2);
    rx_send(P_ACK, 64'h0, 1'b0);
    wait_done(500, ok, b_at, b_after);
    checks++;
    if (ok !== 1'b1 || pkt_q.size() != 2 || pkt_q[0].pid !== P_OUT ||
        pkt_q[1].data !== 64'h0BAD_CAFE_1234_0000) begin
      errors++;
      $display("FAIL midrst_recover: got ok %b n=%0d pid0 %h data1 %h expected 1 2 1 0badcafe12340000",
               ok, pkt_q.size(), pkt_q[0].pid, pkt_q[1].data);
    end
  endtask

  initial begin : main
    txn_start = 1'b0;
    txn_read  = 1'b0;
    txn_wdata = '0;
    rx_valid  = 1'b0;
    rx_error  = 1'b0;
    rx_pid    = '0;
    rx_data   = '0;
    rst_L     = 1'b0;
    test_reset();
    test_write_ack();
    test_write_nak_retry();
    test_read_ack();
    test_read_error();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_usb_txn_controller
`default_nettype wire
